// File: rtl/braille_cell_sequencer.sv
// Buffers ASCII characters in a small FIFO and presents them one at a time as
// 6-dot Grade-1 braille cells, inserting capital/number indicator cells.
module braille_cell_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AUTO_HOLD  = 0,
  parameter int unsigned PREFIX_EN  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  output logic                          char_ready,
  input  logic                          next,
  output logic [5:0]                    cell_out,
  output logic                          cell_valid,
  output logic                          prefix_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned TW        = (AUTO_HOLD > 1) ? $clog2(AUTO_HOLD) : 1;
  localparam int unsigned HOLD_LAST = (AUTO_HOLD == 0) ? 0 : AUTO_HOLD - 1;
  localparam logic [5:0]  CAP_IND   = 6'h20;
  localparam logic [5:0]  NUM_IND   = 6'h3C;

  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_CHAR} state_t;

  state_t          state, state_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_d;
  logic [TW-1:0]   timer;
  logic            next_q;
  logic            num_mode;
  logic [5:0]      char_cell_q;
  logic [7:0]      ascii;
  logic [7:0]      head;
  logic [5:0]      head_cell;
  logic            head_digit, head_upper, need_ind, has_char;
  logic            push, pop, adv, hold_done;
  logic [5:0]      cell_d;
  logic            prefix_d, valid_d;

  // Grade-1 cell for letter index 0 (a) .. 25 (z)
  function automatic logic [5:0] letter_cell(input logic [4:0] idx);
    logic [5:0] c;
    case (idx)
      5'd0:  c = 6'h01; 5'd1:  c = 6'h03; 5'd2:  c = 6'h09; 5'd3:  c = 6'h19;
      5'd4:  c = 6'h11; 5'd5:  c = 6'h0B; 5'd6:  c = 6'h1B; 5'd7:  c = 6'h13;
      5'd8:  c = 6'h0A; 5'd9:  c = 6'h1A; 5'd10: c = 6'h05; 5'd11: c = 6'h07;
      5'd12: c = 6'h0D; 5'd13: c = 6'h1D; 5'd14: c = 6'h15; 5'd15: c = 6'h0F;
      5'd16: c = 6'h1F; 5'd17: c = 6'h17; 5'd18: c = 6'h0E; 5'd19: c = 6'h1E;
      5'd20: c = 6'h25; 5'd21: c = 6'h27; 5'd22: c = 6'h3A; 5'd23: c = 6'h2D;
      5'd24: c = 6'h3D; 5'd25: c = 6'h35;
      default: c = 6'h3F;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] map_cell(input logic [7:0] c);
    logic [5:0] r;
    if (c >= 8'h61 && c <= 8'h7A)      r = letter_cell(5'(c - 8'h61));
    else if (c >= 8'h41 && c <= 8'h5A) r = letter_cell(5'(c - 8'h41));
    else if (c >= 8'h31 && c <= 8'h39) r = letter_cell(5'(c - 8'h31));
    else if (c == 8'h30)               r = letter_cell(5'd9);
    else if (c == 8'h20)               r = 6'h00;
    else                               r = 6'h3F;
    return r;
  endfunction

  // Bit 7 is masked off so it never affects the mapping
  assign ascii      = char_in & 8'h7F;
  assign push       = char_valid & char_ready;
  assign has_char   = (fifo_count != '0);
  assign head       = mem[rd_ptr];
  assign head_cell  = map_cell(head);
  assign head_digit = (head >= 8'h30) && (head <= 8'h39);
  assign head_upper = (head >= 8'h41) && (head <= 8'h5A);
  assign need_ind   = (PREFIX_EN != 0) && (head_upper || (head_digit && !num_mode));
  assign hold_done  = (AUTO_HOLD != 0) && (timer == TW'(HOLD_LAST));
  assign adv        = (next & ~next_q) | hold_done;

  always_comb begin
    count_d = fifo_count;
    if (push && !pop)      count_d = fifo_count + CW'(1);
    else if (!push && pop) count_d = fifo_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ascii;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state and next displayed cell
  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    cell_d   = cell_out;
    prefix_d = prefix_flag;
    valid_d  = cell_valid;
    case (state)
      S_IDLE: begin
        cell_d   = 6'h00;
        prefix_d = 1'b0;
        valid_d  = 1'b0;
        pop      = has_char;
      end
      S_PREFIX: begin
        if (adv) begin
          state_d  = S_CHAR;
          cell_d   = char_cell_q;
          prefix_d = 1'b0;
          valid_d  = 1'b1;
        end
      end
      S_CHAR: begin
        if (adv) begin
          if (has_char) begin
            pop = 1'b1;
          end else begin
            state_d  = S_IDLE;
            cell_d   = 6'h00;
            prefix_d = 1'b0;
            valid_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      valid_d = 1'b1;
      if (need_ind) begin
        state_d  = S_PREFIX;
        cell_d   = head_upper ? CAP_IND : NUM_IND;
        prefix_d = 1'b1;
      end else begin
        state_d  = S_CHAR;
        cell_d   = head_cell;
        prefix_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      char_ready  <= 1'b1;
      cell_out    <= 6'h00;
      cell_valid  <= 1'b0;
      prefix_flag <= 1'b0;
      num_mode    <= 1'b0;
      char_cell_q <= 6'h00;
      timer       <= '0;
      next_q      <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        num_mode    <= head_digit;
        char_cell_q <= head_cell;
      end
      fifo_count  <= count_d;
      char_ready  <= (count_d != CW'(FIFO_DEPTH));
      cell_out    <= cell_d;
      cell_valid  <= valid_d;
      prefix_flag <= prefix_d;
      next_q      <= next;
      // Hold timer restarts whenever the displayed cell changes
      if (state_d != state || pop || state == S_IDLE) timer <= '0;
      else                                            timer <= timer + TW'(1);
    end
  end

endmodule
